// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one sequential ALU among N_REQ requesters.
//
// Ports:
//   i_clk, i_nrst          clock, asynchronous active-low reset
//   i_req                  per-requester request level
//   i_op, i_a, i_b         per-requester opcode (00 add, 01 sub, 10 mul, 11 div) and operands
//   o_gnt                  one-hot grant pulse (cycle after selection)
//   o_valid                one-hot result-valid pulse
//   o_q, o_ovf, o_dz       registered result and flags, held until the next o_valid
//   o_busy                 high while a transaction occupies the ALU (LAUNCH/WAIT)
//   o_alu_a, o_alu_b       operands to the shared ALU, stable from launch until completion
//   o_alu_add/sub/mul/div  single-cycle op strobes to the ALU
//   i_alu_q, i_alu_ovf     ALU result and overflow
//   i_alu_accept           ALU completion pulse, only honoured while waiting
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_REQ      = 4
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [2*N_REQ-1:0]            i_op,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_a,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_b,
  output logic [N_REQ-1:0]              o_gnt,
  output logic [N_REQ-1:0]              o_valid,
  output logic [DATA_WIDTH-1:0]         o_q,
  output logic                          o_ovf,
  output logic                          o_dz,
  output logic                          o_busy,
  output logic [DATA_WIDTH-1:0]         o_alu_a,
  output logic [DATA_WIDTH-1:0]         o_alu_b,
  output logic                          o_alu_add,
  output logic                          o_alu_sub,
  output logic                          o_alu_mul,
  output logic                          o_alu_div,
  input  logic [DATA_WIDTH-1:0]         i_alu_q,
  input  logic                          i_alu_ovf,
  input  logic                          i_alu_accept
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  localparam logic [N_REQ-1:0] OneHot0 = N_REQ'(1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         last_q, last_d;
  logic [IdxW-1:0]         win_q, win_d;
  logic [1:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [N_REQ-1:0]        valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic                    ovf_q, ovf_d;
  logic                    dz_q, dz_d;

  // Unpack the flat request buses so the winner can be indexed directly.
  logic [1:0]            op_arr [N_REQ];
  logic [DATA_WIDTH-1:0] a_arr  [N_REQ];
  logic [DATA_WIDTH-1:0] b_arr  [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign op_arr[k] = i_op[2*k +: 2];
    assign a_arr[k]  = i_a[k*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[k]  = i_b[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: offsets are scanned from farthest to nearest so the requester
  // immediately after last_q is written last and therefore wins.
  logic [IdxW-1:0] pick;
  always_comb begin
    int cand;
    logic [IdxW-1:0] idx;
    cand = 0;
    idx  = '0;
    pick = last_q;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      cand = (int'(last_q) + i) % int'(N_REQ);
      idx  = IdxW'(cand);
      if (i_req[idx]) begin
        pick = idx;
      end
    end
  end

  logic [1:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  assign sel_op = op_arr[pick];
  assign sel_a  = a_arr[pick];
  assign sel_b  = b_arr[pick];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    op_d    = op_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    gnt_d   = '0;
    valid_d = '0;
    res_d   = res_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      StIdle: begin
        if (|i_req) begin
          win_d   = pick;
          last_d  = pick;
          op_d    = sel_op;
          alu_a_d = sel_a;
          alu_b_d = sel_b;
          gnt_d   = OneHot0 << pick;
          if ((sel_op == OpDiv) && (sel_b == '0)) begin
            // Divide by zero completes locally without touching the ALU.
            valid_d = OneHot0 << pick;
            res_d   = '0;
            ovf_d   = 1'b0;
            dz_d    = 1'b1;
          end else begin
            state_d = StLaunch;
          end
        end
      end
      StLaunch: begin
        state_d = StWait;
      end
      StWait: begin
        if (i_alu_accept) begin
          valid_d = OneHot0 << win_q;
          res_d   = i_alu_q;
          ovf_d   = i_alu_ovf;
          dz_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= StIdle;
      last_q  <= IdxW'(N_REQ - 1);
      win_q   <= '0;
      op_q    <= OpAdd;
      alu_a_q <= '0;
      alu_b_q <= '0;
      gnt_q   <= '0;
      valid_q <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      op_q    <= op_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  // Strobes are decoded from the registered state, so they are high only in LAUNCH.
  assign o_alu_add = (state_q == StLaunch) && (op_q == OpAdd);
  assign o_alu_sub = (state_q == StLaunch) && (op_q == OpSub);
  assign o_alu_mul = (state_q == StLaunch) && (op_q == OpMul);
  assign o_alu_div = (state_q == StLaunch) && (op_q == OpDiv);

  assign o_busy  = (state_q != StIdle);
  assign o_gnt   = gnt_q;
  assign o_valid = valid_q;
  assign o_q     = res_q;
  assign o_ovf   = ovf_q;
  assign o_dz    = dz_q;
  assign o_alu_a = alu_a_q;
  assign o_alu_b = alu_b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed requests, a behavioural sequential ALU, and a
// scoreboard monitor that checks every grant and every result as the DUT presents it.
module tb_alu_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_s;
  logic [2*NR-1:0]  op_s;
  logic [NR*DW-1:0] a_s;
  logic [NR*DW-1:0] b_s;
  logic [NR-1:0]    o_gnt, o_valid;
  logic [DW-1:0]    o_q, o_alu_a, o_alu_b;
  logic             o_ovf, o_dz, o_busy;
  logic             s_add, s_sub, s_mul, s_div;
  logic [DW-1:0]    alu_q;
  logic             alu_ovf, alu_accept;

  alu_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_req(req_s), .i_op(op_s), .i_a(a_s), .i_b(b_s),
    .o_gnt(o_gnt), .o_valid(o_valid), .o_q(o_q), .o_ovf(o_ovf), .o_dz(o_dz),
    .o_busy(o_busy), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_add(s_add), .o_alu_sub(s_sub), .o_alu_mul(s_mul), .o_alu_div(s_div),
    .i_alu_q(alu_q), .i_alu_ovf(alu_ovf), .i_alu_accept(alu_accept)
  );

  // Sequential ALU model: add/sub 1 cycle, mul 2, div 4; accept pulses once done.
  function automatic logic [8:0] calc(input logic [1:0] op, input logic [7:0] a,
                                      input logic [7:0] b);
    int ai, bi, r;
    logic ovf;
    ai = int'($signed(a));
    bi = int'($signed(b));
    case (op)
      2'b00: r = ai + bi;
      2'b01: r = ai - bi;
      2'b10: r = ai * bi;
      default: r = (bi == 0) ? 0 : ai / bi;
    endcase
    ovf = (r > 127) || (r < -128);
    return {ovf, r[7:0]};
  endfunction

  function automatic int lat_of(input logic [1:0] op);
    return (op == 2'b10) ? 2 : (op == 2'b11) ? 4 : 1;
  endfunction

  logic alu_busy;
  int   alu_cnt;
  assign alu_accept = alu_busy && (alu_cnt == 0);

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      alu_busy <= 1'b0;
      alu_cnt  <= 0;
      alu_q    <= '0;
      alu_ovf  <= 1'b0;
    end else if (alu_busy) begin
      if (alu_cnt == 0) alu_busy <= 1'b0;
      else alu_cnt <= alu_cnt - 1;
    end else if (s_add | s_sub | s_mul | s_div) begin
      alu_busy <= 1'b1;
      alu_cnt  <= lat_of({s_mul | s_div, s_sub | s_div}) - 1;
      {alu_ovf, alu_q} <= calc({s_mul | s_div, s_sub | s_div}, o_alu_a, o_alu_b);
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         k;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       dz;
  } gnt_t;

  typedef struct {
    int         k;
    logic [7:0] q;
    logic       ovf;
    logic       dz;
  } res_t;

  gnt_t gq[$];
  res_t vq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_gnt = 0, n_valid = 0, n_strobe = 0;
  int         gnt_cyc = 0, valid_cyc = 0, strobe_cyc = 0;
  logic [7:0] cur_a = '0, cur_b = '0;
  gnt_t       mg;
  res_t       mr;
  logic [3:0] strb, exp_strb;

  // Monitor: compares every DUT presentation against the scoreboard queues.
  always @(negedge clk) begin
    if (nrst) begin
      strb     = {s_div, s_mul, s_sub, s_add};
      exp_strb = '0;
      if (o_gnt != '0) begin
        n_gnt++;
        gnt_cyc = cyc;
        if (gq.size() == 0) begin
          chk("unexpected_gnt", 32'(o_gnt), 0);
        end else begin
          mg = gq.pop_front();
          chk("gnt", 32'(o_gnt), 32'(1) << mg.k);
          if (mg.dz) begin
            chk("dz_valid_with_gnt", 32'(o_valid), 32'(1) << mg.k);
          end else begin
            exp_strb = 4'(1) << mg.op;
            cur_a    = mg.a;
            cur_b    = mg.b;
            chk("busy_in_launch", 32'(o_busy), 1);
          end
        end
      end
      if (strb != '0) begin
        n_strobe++;
        strobe_cyc = cyc;
      end
      if ((strb != '0) || (exp_strb != '0)) chk("strobe", 32'(strb), 32'(exp_strb));
      if (o_busy) begin
        chk("alu_a_stable", 32'(o_alu_a), 32'(cur_a));
        chk("alu_b_stable", 32'(o_alu_b), 32'(cur_b));
      end
      if (o_valid != '0) begin
        n_valid++;
        valid_cyc = cyc;
        if (vq.size() == 0) begin
          chk("unexpected_valid", 32'(o_valid), 0);
        end else begin
          mr = vq.pop_front();
          chk("valid", 32'(o_valid), 32'(1) << mr.k);
          chk("q", 32'(o_q), 32'(mr.q));
          chk("ovf", 32'(o_ovf), 32'(mr.ovf));
          chk("dz", 32'(o_dz), 32'(mr.dz));
          chk("idle_at_valid", 32'(o_busy), 0);
        end
      end
    end
  end

  task automatic set_slot(input int k, input logic [1:0] o, input logic [7:0] av,
                          input logic [7:0] bv);
    op_s[2*k +: 2] = o;
    a_s[k*DW +: DW] = av;
    b_s[k*DW +: DW] = bv;
  endtask

  task automatic push_exp(input int k, input logic [1:0] o, input logic [7:0] av,
                          input logic [7:0] bv, input logic [7:0] qv, input logic ovf,
                          input logic dz);
    gnt_t g;
    res_t r;
    g.k = k; g.op = o; g.a = av; g.b = bv; g.dz = dz;
    r.k = k; r.q = qv; r.ovf = ovf; r.dz = dz;
    gq.push_back(g);
    vq.push_back(r);
  endtask

  task automatic wait_gnt(input int target, input string name);
    for (int i = 0; i < 200 && n_gnt < target; i++) begin
      @(posedge clk); #1;
    end
    chk({name, "_gnt_timeout"}, 32'(n_gnt >= target), 1);
  endtask

  task automatic wait_valid(input int target, input string name);
    for (int i = 0; i < 200 && n_valid < target; i++) begin
      @(posedge clk); #1;
    end
    chk({name, "_valid_timeout"}, 32'(n_valid >= target), 1);
  endtask

  // One request from requester k; lat is the hand-computed cycle of o_valid.
  task automatic issue(input int k, input logic [1:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] qv, input logic ovf,
                       input logic dz, input int lat, input string name, output int t0);
    int nv;
    push_exp(k, o, av, bv, qv, ovf, dz);
    nv = n_valid;
    @(posedge clk); #1;
    set_slot(k, o, av, bv);
    req_s[k] = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    req_s[k] = 1'b0;
    wait_valid(nv + 1, name);
    chk({name, "_gnt_lat"}, 32'(gnt_cyc - t0), 1);
    chk({name, "_valid_lat"}, 32'(valid_cyc - t0), 32'(lat));
  endtask

  initial begin
    int t0, base_g, base_v, ns, nv;
    gnt_t g;
    req_s = '0; op_s = '0; a_s = '0; b_s = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 32'({o_gnt, o_valid, o_q, o_ovf, o_dz, o_busy}), 0);
    chk("rst_alu_ops", 32'({o_alu_a, o_alu_b, s_add, s_sub, s_mul, s_div}), 0);
    @(negedge clk);
    nrst = 1'b1;

    // Round robin from reset: requester 0 first, then 1,2,3,0.
    for (int k = 0; k < NR; k++) set_slot(k, 2'b00, 8'(k), 8'd1);
    for (int k = 0; k < NR; k++) push_exp(k, 2'b00, 8'(k), 8'd1, 8'(k + 1), 1'b0, 1'b0);
    push_exp(0, 2'b00, 8'd0, 8'd1, 8'd1, 1'b0, 1'b0);
    base_g = n_gnt;
    base_v = n_valid;
    @(posedge clk); #1;
    req_s = '1;
    wait_gnt(base_g + 5, "rr");
    req_s = '0;
    wait_valid(base_v + 5, "rr");

    // Single add with latency and strobe timing.
    issue(0, 2'b00, 8'd5, 8'd7, 8'd12, 1'b0, 1'b0, 3, "add", t0);
    chk("add_strobe_cyc", 32'(strobe_cyc - t0), 1);

    // Divide by zero: no ALU strobe at all.
    ns = n_strobe;
    issue(2, 2'b11, 8'd9, 8'd0, 8'd0, 1'b0, 1'b1, 1, "dz", t0);
    chk("dz_no_strobe", 32'(n_strobe - ns), 0);

    // Mul then div on requester 1.
    issue(1, 2'b10, 8'hFD, 8'd4, 8'hF4, 1'b0, 1'b0, 4, "mul", t0);
    issue(1, 2'b11, 8'd20, 8'd6, 8'd3, 1'b0, 1'b0, 6, "div", t0);

    // Signed overflow on add.
    issue(0, 2'b00, 8'd127, 8'd1, 8'h80, 1'b1, 1'b0, 3, "ovf", t0);

    // Reset while waiting on a divide: transaction abandoned, no result.
    g.k = 2; g.op = 2'b11; g.a = 8'd100; g.b = 8'd7; g.dz = 1'b0;
    gq.push_back(g);
    base_g = n_gnt;
    nv = n_valid;
    @(posedge clk); #1;
    set_slot(2, 2'b11, 8'd100, 8'd7);
    req_s[2] = 1'b1;
    @(posedge clk); #1;
    req_s[2] = 1'b0;
    wait_gnt(base_g + 1, "rstdiv");
    @(posedge clk); #1;
    chk("rstdiv_busy_wait", 32'(o_busy), 1);
    nrst = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'({o_gnt, o_valid, o_q, o_ovf, o_dz, o_busy}), 0);
    chk("rst_mid_alu_ops", 32'({o_alu_a, o_alu_b, s_add, s_sub, s_mul, s_div}), 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_no_valid", 32'(n_valid - nv), 0);

    // After reset, requester 0 wins over requester 3.
    set_slot(0, 2'b00, 8'd1, 8'd2);
    set_slot(3, 2'b01, 8'd10, 8'd4);
    push_exp(0, 2'b00, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0);
    push_exp(3, 2'b01, 8'd10, 8'd4, 8'd6, 1'b0, 1'b0);
    base_g = n_gnt;
    base_v = n_valid;
    req_s[0] = 1'b1;
    req_s[3] = 1'b1;
    wait_gnt(base_g + 1, "post_rst0");
    req_s[0] = 1'b0;
    wait_gnt(base_g + 2, "post_rst3");
    req_s[3] = 1'b0;
    wait_valid(base_v + 2, "post_rst");

    repeat (4) @(posedge clk);
    #1;
    chk("gnt_queue_empty", 32'(gq.size()), 0);
    chk("valid_queue_empty", 32'(vq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 8, operand/result width.
- N_REQ, 4, number of requesters (2..8).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, clock.
- i_nrst, in, 1, reset, asynchronous, active-low.
- i_req, in, N_REQ, per-requester request level.
- i_op, in, 2*N_REQ, per-requester opcode, slice k = [2k+1:2k]: 00 add, 01 sub, 10 mul, 11 div.
- i_a, in, N_REQ*DATA_WIDTH, per-requester signed operand a.
- i_b, in, N_REQ*DATA_WIDTH, per-requester signed operand b.
- o_gnt, out, N_REQ, one-hot, one-cycle grant pulse.
- o_valid, out, N_REQ, one-hot, one-cycle result-valid pulse.
- o_q, out, DATA_WIDTH, signed result.
- o_ovf, out, 1, overflow flag.
- o_dz, out, 1, divide-by-zero flag.
- o_busy, out, 1, high in any state other than IDLE.
- o_alu_a, out, DATA_WIDTH, operand a to shared ALU.
- o_alu_b, out, DATA_WIDTH, operand b to shared ALU.
- o_alu_add, o_alu_sub, o_alu_mul, o_alu_div, out, 1 each, ALU op strobes.
- i_alu_q, in, DATA_WIDTH, ALU result.
- i_alu_ovf, in, 1, ALU overflow.
- i_alu_accept, in, 1, ALU one-cycle completion pulse.

Function
REQ-003 The block SHALL share one sequential ALU among N_REQ requesters with a 3-state FSM: IDLE, LAUNCH, WAIT.

REQ-004 In IDLE with any i_req bit high, the block SHALL select a winner k by round-robin.
- Search starts at last_served+1, modulo N_REQ.

REQ-005 On the selecting edge, the block SHALL capture i_op, i_a and i_b slice k into o_alu_a, o_alu_b and an op register, and drive o_gnt[k]=1 for exactly the following cycle.

REQ-006 The block SHALL update last_served to k on every grant, including divide-by-zero grants.

REQ-007 If the winner's op is div and its i_b slice is 0, the block SHALL NOT launch the ALU.
- Next cycle: o_gnt[k]=1 and o_valid[k]=1 together, o_q=0, o_dz=1, o_ovf=0.
- State remains IDLE.

REQ-008 Otherwise the block SHALL enter LAUNCH.
- Exactly one ALU strobe, per the captured op, is high for that single cycle.
- All strobes are low in every other cycle.

REQ-009 LAUNCH SHALL always advance to WAIT on the next edge.

REQ-010 o_alu_a and o_alu_b SHALL hold the captured operands, unchanged, from LAUNCH until leaving WAIT.

REQ-011 In WAIT, on a cycle with i_alu_accept=1, the block SHALL register the result and return to IDLE.
- Registered result: o_q=i_alu_q, o_ovf=i_alu_ovf, o_dz=0.
- o_valid[k]=1 for exactly the next cycle.

REQ-012 i_alu_accept outside WAIT SHALL be ignored.

REQ-013 o_q, o_ovf and o_dz SHALL hold their last value until the next o_valid pulse.

REQ-014 Requests SHALL be sampled only in IDLE.
- A requester may drop i_req before its grant with no effect.
- A requester holding i_req after o_valid is re-arbitrated as a new request.

REQ-015 The cycle in which o_valid is high SHALL also be an IDLE cycle, so back-to-back service has no dead cycle.

REQ-016 Latency for a non-div-by-zero request granted at edge E0 SHALL be:
- o_gnt and strobe in cycle E0+1;
- o_valid one cycle after the cycle in which i_alu_accept is seen.
- Add/sub with a one-cycle ALU: i_req seen in cycle 0, o_valid in cycle 3.

REQ-017 o_busy SHALL be 1 in LAUNCH and WAIT, and 0 in IDLE.

REQ-018 Requester k=N_REQ-1 SHALL be treated as last_served after reset, so requester 0 has first priority.

Reset
REQ-019 Asserting i_nrst low SHALL asynchronously clear all of:
- FSM to IDLE, last_served to N_REQ-1;
- o_gnt, o_valid, o_q, o_ovf, o_dz, o_busy;
- o_alu_a, o_alu_b;
- all ALU strobes.

REQ-020 Reset mid-operation (LAUNCH or WAIT) SHALL abandon the transaction with no o_valid issued.
- The ALU shares i_nrst, so both return to idle together.

Verification
REQ-021 The bench SHALL use the team's sequential ALU (DATA_WIDTH=8) as the shared ALU and cover these scenarios:
- Single add: req0 op=00 a=5 b=7 in cycle 0 -> o_gnt[0] in cycle 1, o_alu_add high only in cycle 1, o_valid[0] in cycle 3, o_q=12, o_ovf=0.
- Round-robin: req0..req3 all held high, each op=00 a=k b=1 -> grants in order 0,1,2,3,0; each o_valid[k] carries o_q=k+1; no requester granted twice before all four served.
- Divide by zero: req2 op=11 a=9 b=0 -> o_gnt[2] and o_valid[2] in the same cycle, o_dz=1, o_q=0, no ALU strobe ever high.
- Mul then div: req1 op=10 a=-3 b=4 -> o_q=-12; then req1 op=11 a=20 b=6 -> o_q=3; strobes single-cycle; operands stable until o_valid.
- Overflow: req0 op=00 a=127 b=1 -> o_valid[0] with o_ovf=1.
- Reset in WAIT: during a div, drop i_nrst for 1 cycle -> all outputs 0, no o_valid; next req3 request is granted to requester 0 first if req0 is also pending.
